// File: rtl/riscv_v_pkg.sv
// Shared types for the vector integer adder: op codes, adder control bundle, element-size helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package riscv_v_pkg;

    localparam int RISCV_V_MAX_LMUL = 8;

    // One-hot element size: bit0=8b, bit1=16b, bit2=32b, bit3=64b.
    typedef logic [3:0] osize_vector_t;

    localparam osize_vector_t OSIZE_8  = 4'b0001;
    localparam osize_vector_t OSIZE_16 = 4'b0010;
    localparam osize_vector_t OSIZE_32 = 4'b0100;
    localparam osize_vector_t OSIZE_64 = 4'b1000;

    typedef enum logic [3:0] {
        ADD, SUB, MIN, MAX, SEQ, SNE, SLT, SGT, RED_SUM, RED_MIN, RED_MAX
    } riscv_v_adder_op_t;

    typedef struct packed {
        logic          valid_adder;
        logic          is_add;
        logic          is_sub;
        logic          is_max;
        logic          is_set_eq;
        logic          is_set_ne;
        logic          is_set_lt;
        logic          is_set_gt;
        logic          is_reduct;
        logic          is_reduct_n;
        logic          is_arithmetic;
        logic          is_min_max;
        logic          is_signed;
        osize_vector_t osize_vector;
        osize_vector_t is_greater_osize_vector;
    } riscv_v_adder_ctrl_t;

    // Bit i set when the element is wider than size i; drives carry propagation across lanes.
    function automatic osize_vector_t greater_osize(input osize_vector_t o);
        return {1'b0, o[3], o[3] | o[2], o[3] | o[2] | o[1]};
    endfunction

    // Bytes per element; a malformed size falls back to byte elements.
    function automatic logic [3:0] osize_bytes(input osize_vector_t o);
        case (o)
            OSIZE_16: return 4'd2;
            OSIZE_32: return 4'd4;
            OSIZE_64: return 4'd8;
            default:  return 4'd1;
        endcase
    endfunction

    // Low-order mask covering one element.
    function automatic logic [63:0] elem_mask(input osize_vector_t o);
        case (o)
            OSIZE_16: return 64'h0000_0000_0000_FFFF;
            OSIZE_32: return 64'h0000_0000_FFFF_FFFF;
            OSIZE_64: return 64'hFFFF_FFFF_FFFF_FFFF;
            default:  return 64'h0000_0000_0000_00FF;
        endcase
    endfunction

endpackage

// File: rtl/riscv_v_adder_ctrl_dec.sv
// Decodes op/size/signedness into the adder control bundle and a per-byte reduction identity chunk.
// Latency: combinational.
// Backpressure: none; outputs are all-zero while valid is low.
module riscv_v_adder_ctrl_dec
    import riscv_v_pkg::*;
#(
    parameter int DATA_WIDTH = 128
) (
    input  logic                  valid,
    input  riscv_v_adder_op_t     op,
    input  logic                  is_signed,
    input  osize_vector_t         osize,
    output riscv_v_adder_ctrl_t   ctrl,
    output logic [DATA_WIDTH-1:0] identity
);

    logic [63:0] emask;
    logic [63:0] msb;
    logic [63:0] id_elem;
    logic [3:0]  eb;
    logic [2:0]  lane;

    // Control decode plus identity replicated into every element position of the chunk.
    always_comb begin
        ctrl     = '0;
        identity = '0;
        id_elem  = '0;
        lane     = '0;
        emask    = elem_mask(osize);
        msb      = emask ^ (emask >> 1);
        eb       = osize_bytes(osize);
        if (valid) begin
            ctrl.valid_adder             = 1'b1;
            ctrl.is_add                  = op inside {ADD, RED_SUM};
            ctrl.is_sub                  = !(op inside {ADD, RED_SUM});
            ctrl.is_max                  = op inside {MAX, RED_MAX};
            ctrl.is_set_eq               = (op == SEQ);
            ctrl.is_set_ne               = (op == SNE);
            ctrl.is_set_lt               = (op == SLT);
            ctrl.is_set_gt               = (op == SGT);
            ctrl.is_reduct               = op inside {RED_SUM, RED_MIN, RED_MAX};
            ctrl.is_reduct_n             = !(op inside {RED_SUM, RED_MIN, RED_MAX});
            ctrl.is_arithmetic           = op inside {ADD, SUB, RED_SUM};
            ctrl.is_min_max              = op inside {MIN, MAX, RED_MIN, RED_MAX};
            ctrl.is_signed               = is_signed;
            ctrl.osize_vector            = osize;
            ctrl.is_greater_osize_vector = greater_osize(osize);
            case (op)
                RED_MIN: id_elem = is_signed ? (emask ^ msb) : emask;
                RED_MAX: id_elem = is_signed ? msb : '0;
                default: id_elem = '0;
            endcase
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                lane = 3'(b) & 3'(eb - 4'd1);
                identity[b*8 +: 8] = 8'(id_elem >> {lane, 3'b000});
            end
        end
    end

endmodule

// File: rtl/riscv_v_adder_seq.sv
// Sequences one vector add-class op over 1..MAX_CHUNKS chunks through the adder; reductions fold into a scalar.
// Latency: element-wise 1 cycle consume->rsp_valid; reductions respond 1 cycle after the last chunk.
// Backpressure: element-wise chunks stall while the output register is full and unaccepted; rsp held until rsp_ready.
module riscv_v_adder_seq
    import riscv_v_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int NUM_BYTES  = DATA_WIDTH/8,
    parameter int MAX_CHUNKS = RISCV_V_MAX_LMUL
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  riscv_v_adder_op_t             req_op,
    input  logic                          req_signed,
    input  osize_vector_t                 req_osize,
    input  logic [$clog2(MAX_CHUNKS):0]   req_num_chunks,
    input  logic [63:0]                   req_scalar,
    input  logic                          src_valid,
    output logic                          src_ready,
    input  logic [DATA_WIDTH-1:0]         src_a,
    input  logic [DATA_WIDTH-1:0]         src_b,
    input  logic [NUM_BYTES-1:0]          src_mask,
    output riscv_v_adder_ctrl_t           adder_ctrl,
    output logic [DATA_WIDTH-1:0]         adder_srca,
    output logic [DATA_WIDTH-1:0]         adder_srcb,
    output logic [NUM_BYTES-1:0]          adder_srcb_valid,
    input  logic [DATA_WIDTH-1:0]         adder_result,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_last
);

    localparam int CW = $clog2(MAX_CHUNKS) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t              state, state_nxt;
    riscv_v_adder_op_t   op_q;
    logic                signed_q;
    osize_vector_t       osize_q;
    logic [CW-1:0]       num_q;
    logic [CW-1:0]       cnt;
    logic [63:0]         acc;
    logic [63:0]         acc_nxt;
    logic [DATA_WIDTH-1:0] identity;
    logic                is_red, issue, last_chunk;
    logic                req_fire, src_fire, rsp_fire;

    assign is_red     = op_q inside {RED_SUM, RED_MIN, RED_MAX};
    assign req_ready  = (state == IDLE);
    assign src_ready  = (state == RUN) && (is_red || !rsp_valid || rsp_ready);
    assign req_fire   = req_valid && req_ready;
    assign src_fire   = src_valid && src_ready;
    assign rsp_fire   = rsp_valid && rsp_ready;
    assign issue      = (state == RUN) && src_valid;
    assign last_chunk = ((cnt + CW'(1)) == num_q);
    // The adder leaves the folded value in the top element; bring it down to bit 0.
    assign acc_nxt    = 64'(adder_result[DATA_WIDTH-1 -: 64] >> (7'd64 - {osize_bytes(osize_q), 3'b000}));

    riscv_v_adder_ctrl_dec #(.DATA_WIDTH(DATA_WIDTH)) u_dec (
        .valid     (issue),
        .op        (op_q),
        .is_signed (signed_q),
        .osize     (osize_q),
        .ctrl      (adder_ctrl),
        .identity  (identity)
    );

    // Operand steering: element-wise passes through; reductions pad masked bytes and feed the accumulator.
    always_comb begin
        adder_srca       = '0;
        adder_srcb       = '0;
        adder_srcb_valid = '0;
        if (issue) begin
            if (is_red) begin
                for (int b = 0; b < NUM_BYTES; b++) begin
                    adder_srca[b*8 +: 8] = src_mask[b] ? src_a[b*8 +: 8] : identity[b*8 +: 8];
                end
                adder_srcb       = {{(DATA_WIDTH-64){1'b0}}, acc};
                adder_srcb_valid = NUM_BYTES'((16'd1 << osize_bytes(osize_q)) - 16'd1);
            end else begin
                adder_srca       = src_a;
                adder_srcb       = src_b;
                adder_srcb_valid = src_mask;
            end
        end
    end

    // Next-state: reductions finish in DONE, element-wise ops drain the last result.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_fire) state_nxt = RUN;
            RUN:     if (src_fire && last_chunk) state_nxt = is_red ? DONE : DRAIN;
            DRAIN:   if (rsp_fire) state_nxt = IDLE;
            DONE:    if (rsp_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Request latch, chunk counter and reduction accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= ADD;
            signed_q <= 1'b0;
            osize_q  <= OSIZE_8;
            num_q    <= CW'(1);
            cnt      <= '0;
            acc      <= '0;
        end else begin
            if (req_fire) begin
                op_q     <= req_op;
                signed_q <= req_signed;
                osize_q  <= req_osize;
                num_q    <= (req_num_chunks == '0 || req_num_chunks > CW'(MAX_CHUNKS))
                            ? CW'(1) : req_num_chunks;
                cnt      <= '0;
                if (req_op inside {RED_SUM, RED_MIN, RED_MAX})
                    acc <= req_scalar & elem_mask(req_osize);
            end
            if (src_fire) begin
                cnt <= cnt + CW'(1);
                if (is_red) acc <= acc_nxt;
            end
            if (state != IDLE && state_nxt == IDLE) cnt <= '0;
        end
    end

    // Output register: loaded per element-wise chunk or once at the end of a reduction, held until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_last  <= 1'b0;
        end else if (src_fire && !is_red) begin
            rsp_valid <= 1'b1;
            rsp_data  <= adder_result;
            rsp_last  <= last_chunk;
        end else if (src_fire && last_chunk) begin
            rsp_valid <= 1'b1;
            rsp_data  <= {{(DATA_WIDTH-64){1'b0}}, acc_nxt};
            rsp_last  <= 1'b1;
        end else if (rsp_fire) begin
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_riscv_v_adder_seq.sv
// Scoreboard bench for riscv_v_adder_seq with a behavioural stand-in for the adder datapath.
// Latency: n/a.
// Backpressure: rsp_ready is driven by the stimulus to exercise stalls.
module tb_riscv_v_adder_seq;
    import riscv_v_pkg::*;

    localparam int DW = 128;
    localparam int NB = DW/8;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                req_valid, req_ready, req_signed;
    riscv_v_adder_op_t   req_op;
    osize_vector_t       req_osize;
    logic [3:0]          req_num_chunks;
    logic [63:0]         req_scalar;
    logic                src_valid, src_ready;
    logic [DW-1:0]       src_a, src_b;
    logic [NB-1:0]       src_mask;
    riscv_v_adder_ctrl_t adder_ctrl;
    logic [DW-1:0]       adder_srca, adder_srcb, adder_result;
    logic [NB-1:0]       adder_srcb_valid;
    logic                rsp_valid, rsp_ready, rsp_last;
    logic [DW-1:0]       rsp_data;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    riscv_v_adder_seq dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_signed(req_signed),
        .req_osize(req_osize), .req_num_chunks(req_num_chunks), .req_scalar(req_scalar),
        .src_valid(src_valid), .src_ready(src_ready), .src_a(src_a), .src_b(src_b), .src_mask(src_mask),
        .adder_ctrl(adder_ctrl), .adder_srca(adder_srca), .adder_srcb(adder_srcb),
        .adder_srcb_valid(adder_srcb_valid), .adder_result(adder_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last)
    );

    function automatic logic signed [63:0] sx(input logic [63:0] x, input int s);
        logic signed [63:0] t;
        t = $signed(x << (64 - s));
        return t >>> (64 - s);
    endfunction

    function automatic logic less(input logic [63:0] x, input logic [63:0] y, input int s, input logic sg);
        if (sg) return sx(x, s) < sx(y, s);
        return x < y;
    endfunction

    // Behavioural adder: element-wise ops per lane, reductions folded into the top element.
    function automatic logic [DW-1:0] adder_model(input riscv_v_adder_ctrl_t c,
                                                  input logic [DW-1:0] a, input logic [DW-1:0] b);
        int s;
        logic [63:0] m, ea, eb, r;
        logic [DW-1:0] res;
        res = '0;
        if (!c.valid_adder) return res;
        s = c.osize_vector[0] ? 8 : c.osize_vector[1] ? 16 : c.osize_vector[2] ? 32 : 64;
        m = (s == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << s) - 64'd1);
        if (c.is_reduct) begin
            r = b[63:0] & m;
            for (int e = 0; e < DW/s; e++) begin
                ea = 64'(a >> (e*s)) & m;
                if (c.is_arithmetic) r = (r + ea) & m;
                else if (c.is_max ? less(r, ea, s, c.is_signed) : less(ea, r, s, c.is_signed)) r = ea;
            end
            res = DW'(r) << (DW - s);
        end else begin
            for (int e = 0; e < DW/s; e++) begin
                ea = 64'(a >> (e*s)) & m;
                eb = 64'(b >> (e*s)) & m;
                if (c.is_add)          r = ea + eb;
                else if (c.is_min_max) r = (c.is_max ? less(ea, eb, s, c.is_signed) : less(eb, ea, s, c.is_signed)) ? eb : ea;
                else if (c.is_set_eq)  r = {63'd0, ea == eb};
                else if (c.is_set_ne)  r = {63'd0, ea != eb};
                else if (c.is_set_lt)  r = {63'd0, less(ea, eb, s, c.is_signed)};
                else if (c.is_set_gt)  r = {63'd0, less(eb, ea, s, c.is_signed)};
                else                   r = ea - eb;
                res = res | (DW'(r & m) << (e*s));
            end
        end
        return res;
    endfunction

    assign adder_result = adder_model(adder_ctrl, adder_srca, adder_srcb);

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic push(input logic [DW-1:0] d, input logic l);
        exp_t e;
        e.data = d;
        e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic do_req(input riscv_v_adder_op_t op, input logic sg, input osize_vector_t os,
                          input logic [3:0] n, input logic [63:0] sc);
        int t;
        t = 0;
        while (!req_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (!req_ready) timeout("req_ready_wait");
        req_valid = 1'b1; req_op = op; req_signed = sg; req_osize = os;
        req_num_chunks = n; req_scalar = sc;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drive_chunk(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [NB-1:0] m);
        src_valid = 1'b1; src_a = a; src_b = b; src_mask = m;
    endtask

    task automatic wait_src();
        int t;
        for (t = 0; t < 200; t++) begin
            @(negedge clk);
            if (src_ready) break;
        end
        if (!src_ready) timeout("src_handshake");
        else begin
            @(posedge clk); #1;
        end
        src_valid = 1'b0;
    endtask

    // Waits for the final handshake and checks the sequencer is idle right after it.
    task automatic wait_done(input string name);
        int t;
        logic hit;
        hit = 1'b0;
        for (t = 0; t < 200 && !hit; t++) begin
            @(negedge clk);
            hit = rsp_valid && rsp_ready && rsp_last;
        end
        if (!hit) timeout({name, "_last"});
        else begin
            @(posedge clk); #1;
            check({name, "_req_ready_after"}, DW'(req_ready), DW'(1));
        end
    endtask

    // Monitor: every accepted response is compared against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rsp_unexpected: got data %h last %0d, required no response", rsp_data, rsp_last);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_data", rsp_data, e.data);
                check("rsp_last", DW'(rsp_last), DW'(e.last));
            end
        end
    end

    initial begin
        riscv_v_adder_ctrl_t ctrl_exp;
        logic [DW-1:0] ones8, v;
        int t;

        rst_n = 1'b1; req_valid = 1'b0; req_op = ADD; req_signed = 1'b0; req_osize = OSIZE_8;
        req_num_chunks = 4'd1; req_scalar = '0; src_valid = 1'b0; src_a = '0; src_b = '0;
        src_mask = '0; rsp_ready = 1'b1;
        ones8 = {NB{8'h01}};
        #1 rst_n = 1'b0;
        #2;
        check("rst_req_ready",  DW'(req_ready), DW'(1));
        check("rst_src_ready",  DW'(src_ready), DW'(0));
        check("rst_rsp_valid",  DW'(rsp_valid), DW'(0));
        check("rst_rsp_last",   DW'(rsp_last),  DW'(0));
        check("rst_rsp_data",   rsp_data,       DW'(0));
        check("rst_adder_ctrl", DW'(adder_ctrl), DW'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        src_valid = 1'b1;
        #1 check("idle_ctrl_off", DW'(adder_ctrl), DW'(0));
        src_valid = 1'b0;

        // ADD 8b, 2 chunks: 0x01 + 0xFF wraps to 0x00.
        do_req(ADD, 1'b0, OSIZE_8, 4'd2, 64'd0);
        push('0, 1'b0);
        push('0, 1'b1);
        drive_chunk(ones8, {NB{8'hFF}}, '1);
        #1;
        ctrl_exp = '0;
        ctrl_exp.valid_adder = 1'b1; ctrl_exp.is_add = 1'b1; ctrl_exp.is_reduct_n = 1'b1;
        ctrl_exp.is_arithmetic = 1'b1; ctrl_exp.osize_vector = OSIZE_8;
        check("add_ctrl", DW'(adder_ctrl), DW'(ctrl_exp));
        wait_src();
        drive_chunk(ones8, {NB{8'hFF}}, '1);
        wait_src();
        wait_done("add");

        // RED_SUM 32b: 5 + 3 chunks of four 1s = 17.
        do_req(RED_SUM, 1'b0, OSIZE_32, 4'd3, 64'd5);
        push(DW'(128'h11), 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive_chunk({4{32'd1}}, '0, '1);
            wait_src();
        end
        wait_done("red_sum");

        // RED_MAX signed 16b: {-3, masked, -9, 2}, upper half masked, scalar -100 -> 2.
        do_req(RED_MAX, 1'b1, OSIZE_16, 4'd1, 64'hFFFF_FFFF_FFFF_FF9C);
        push(DW'(128'h2), 1'b1);
        drive_chunk({64'd0, 16'h0002, 16'hFFF7, 16'h0007, 16'hFFFD}, '0, 16'h00F3);
        #1 check("red_srcb_valid", DW'(adder_srcb_valid), DW'(16'h0003));
        wait_src();
        wait_done("red_max");

        // SLT unsigned 8b, 2 chunks, response stalled 4 cycles.
        rsp_ready = 1'b0;
        do_req(SLT, 1'b0, OSIZE_8, 4'd2, 64'd0);
        push(ones8, 1'b0);
        push(ones8, 1'b1);
        drive_chunk({NB{8'h10}}, {NB{8'h20}}, '1);
        wait_src();
        drive_chunk({NB{8'h10}}, {NB{8'h20}}, '1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_rsp_valid", DW'(rsp_valid), DW'(1));
            check("stall_rsp_data",  rsp_data,       ones8);
            check("stall_src_ready", DW'(src_ready), DW'(0));
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_src();
        wait_done("slt");

        // Reset during chunk 2 of a 4-chunk ADD: nothing may come out.
        rsp_ready = 1'b0;
        do_req(ADD, 1'b0, OSIZE_8, 4'd4, 64'd0);
        drive_chunk(ones8, ones8, '1);
        wait_src();
        drive_chunk(ones8, ones8, '1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_rsp_valid", DW'(rsp_valid), DW'(0));
        check("abort_req_ready", DW'(req_ready), DW'(1));
        check("abort_src_ready", DW'(src_ready), DW'(0));
        src_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("post_rst_req_ready", DW'(req_ready), DW'(1));
        check("post_rst_rsp_valid", DW'(rsp_valid), DW'(0));

        // SUB 8b single chunk: 3 - 1 = 2.
        do_req(SUB, 1'b0, OSIZE_8, 4'd1, 64'd0);
        push({NB{8'h02}}, 1'b1);
        drive_chunk({NB{8'h03}}, ones8, '1);
        wait_src();
        wait_done("sub");

        // num_chunks = 0 behaves as a single chunk: 5 + 3 = 8.
        do_req(ADD, 1'b0, OSIZE_8, 4'd0, 64'd0);
        push({NB{8'h08}}, 1'b1);
        drive_chunk({NB{8'h05}}, {NB{8'h03}}, '1);
        wait_src();
        wait_done("zero_chunks");
        repeat (5) @(posedge clk);
        #1;
        check("zero_chunks_no_extra", DW'(rsp_valid), DW'(0));

        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        v = DW'(exp_q.size());
        check("scoreboard_empty", v, DW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
